// File: rtl/multicycle_alu_pkg.sv
// rtl/multicycle_alu_pkg.sv - shared op codes, FSM states and widths for the RV64I execution unit
//
// Package alu_pkg: also imported by the ALU control decoder, so the
// op-code values below are the single source of truth for both sides
// of the operation-code interface.
package alu_pkg;

    localparam int XLEN = 64;
    localparam int WLEN = 32;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_AND     = 4'b0001;
    localparam logic [3:0] ALU_OR      = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SLT     = 4'b0101;
    localparam logic [3:0] ALU_SLTU    = 4'b0110;
    localparam logic [3:0] ALU_SLL     = 4'b0111;
    localparam logic [3:0] ALU_SRL     = 4'b1000;
    localparam logic [3:0] ALU_SRA     = 4'b1001;
    localparam logic [3:0] ALU_ADDW    = 4'b1010;
    localparam logic [3:0] ALU_SUBW    = 4'b1011;
    localparam logic [3:0] ALU_SLLW    = 4'b1100;
    localparam logic [3:0] ALU_SRLW    = 4'b1101;
    localparam logic [3:0] ALU_SRAW    = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL)  || (op == ALU_SRL)  || (op == ALU_SRA) ||
               (op == ALU_SLLW) || (op == ALU_SRLW) || (op == ALU_SRAW);
    endfunction

    // W ops occupy the contiguous code range 1010..1110.
    function automatic logic is_word_op(input logic [3:0] op);
        return (op >= ALU_ADDW) && (op <= ALU_SRAW);
    endfunction

    function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] w);
        return {{(XLEN-WLEN){w[WLEN-1]}}, w};
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - start/busy/done request bus between control FSM and execution unit
//
// master (control FSM): drives start, operation, A, B; observes result, zero, busy, done.
// slave  (multicycle_alu): the reverse.
interface multicycle_alu_if;
    import alu_pkg::*;

    logic            start;
    logic [3:0]      operation;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;
    logic            done;

    modport master (
        output start, operation, A, B,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, operation, A, B,
        output result, zero, busy, done
    );
endinterface

// File: rtl/multicycle_alu_comb_core.sv
// rtl/multicycle_alu_comb_core.sv - single-cycle result selection for the execution unit
//
// Module alu_comb_core, purely combinational.
// Ports:
//   op        in  4   latched operation code
//   a, b      in  64  latched operands
//   shift_res in  64  shifted word from the shift unit (iterative or barrel)
//   res       out 64  final 64-bit result; W forms are sign-extended from bit 31
module alu_comb_core
    import alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] shift_res,
    output logic [XLEN-1:0] res
);

    logic [WLEN-1:0] addw_r;
    logic [WLEN-1:0] subw_r;

    always_comb begin
        addw_r = a[WLEN-1:0] + b[WLEN-1:0];
        subw_r = a[WLEN-1:0] - b[WLEN-1:0];
        res    = '0;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_SUB:  res = a - b;
            ALU_XOR:  res = a ^ b;
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  res = shift_res;
            ALU_ADDW: res = sext_w(addw_r);
            ALU_SUBW: res = sext_w(subw_r);
            // Upper half of the working word is don't-care for W shifts.
            ALU_SLLW,
            ALU_SRLW,
            ALU_SRAW: res = sext_w(shift_res[WLEN-1:0]);
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multi-cycle RV64I execution unit with start/busy/done handshake
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of multicycle_alu_if (start, operation, A, B,
//          result, zero, busy, done)
// Build option MULTICYCLE_ALU_FAST_SHIFT_EN: when defined, shifts use a
// barrel shifter and finish in one EXEC cycle; otherwise they shift one
// bit per cycle under a down-counter.
module multicycle_alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_alu_if.slave   bus
);

    alu_state_t      state, state_nxt;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [XLEN-1:0] shift_res;
    logic [XLEN-1:0] core_res;
    logic            shift_busy;   // EXEC must stay for another shift step

`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
    always_comb begin
        shift_res = a_q;
        case (op_q)
            ALU_SLL:  shift_res = a_q << b_q[5:0];
            ALU_SRL:  shift_res = a_q >> b_q[5:0];
            ALU_SRA:  shift_res = $signed(a_q) >>> b_q[5:0];
            ALU_SLLW: shift_res = {{(XLEN-WLEN){1'b0}}, a_q[WLEN-1:0] << b_q[4:0]};
            ALU_SRLW: shift_res = {{(XLEN-WLEN){1'b0}}, a_q[WLEN-1:0] >> b_q[4:0]};
            ALU_SRAW: shift_res = {{(XLEN-WLEN){1'b0}}, $signed(a_q[WLEN-1:0]) >>> b_q[4:0]};
            default:  shift_res = a_q;
        endcase
    end

    assign shift_busy = 1'b0;
`else
    logic [XLEN-1:0] wrk;
    logic [XLEN-1:0] wrk_step;
    logic [5:0]      cnt;

    // One-bit step. W words are loaded zero-extended, so srlw needs no
    // special case; sraw replicates bit 31 of the working word.
    always_comb begin
        wrk_step = wrk;
        case (op_q)
            ALU_SLL,
            ALU_SLLW: wrk_step = {wrk[XLEN-2:0], 1'b0};
            ALU_SRL,
            ALU_SRLW: wrk_step = {1'b0, wrk[XLEN-1:1]};
            ALU_SRA:  wrk_step = {wrk[XLEN-1], wrk[XLEN-1:1]};
            ALU_SRAW: wrk_step = {{(XLEN-WLEN){1'b0}}, wrk[WLEN-1], wrk[WLEN-1:1]};
            default:  wrk_step = wrk;
        endcase
    end

    assign shift_res  = wrk;
    assign shift_busy = is_shift_op(op_q) && (cnt != 6'd0);
`endif

    alu_comb_core u_core (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .shift_res (shift_res),
        .res       (core_res)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_EXEC;
            ST_EXEC: if (!shift_busy) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy   = (state != ST_IDLE);
        bus.done   = (state == ST_DONE);
        bus.result = result_q;
        bus.zero   = zero_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
            wrk      <= '0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.operation;
                        a_q  <= bus.A;
                        b_q  <= bus.B;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
                        if (is_word_op(bus.operation)) begin
                            wrk <= {{(XLEN-WLEN){1'b0}}, bus.A[WLEN-1:0]};
                            cnt <= {1'b0, bus.B[4:0]};
                        end else begin
                            wrk <= bus.A;
                            cnt <= bus.B[5:0];
                        end
`endif
                    end
                end
                ST_EXEC: begin
                    if (shift_busy) begin
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
                        wrk <= wrk_step;
                        cnt <= cnt - 6'd1;
`endif
                    end else begin
                        result_q <= core_res;
                        zero_q   <= (core_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed table-driven bench for multicycle_alu
module tb_multicycle_alu;
    import alu_pkg::*;

`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_alu_if bus ();

    multicycle_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        z;
        int          lat;   // iterative-build latency in edges after N
    } vec_t;

    vec_t vecs[19];

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge where done is seen.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] r, output logic z, output int lat);
        bus.start     = 1'b1;
        bus.operation = op;
        bus.A         = a;
        bus.B         = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = '1;
        bus.B     = '1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        r = bus.result;
        z = bus.zero;
    endtask

    logic [63:0] r;
    logic        z;
    int          lat;
    int          dones;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start     = 1'b0;
        bus.operation = ALU_ADD;
        bus.A = '0;
        bus.B = '0;

        vecs[0]  = '{ALU_ADD,  64'd5, 64'd7, 64'd12, 1'b0, 1};
        vecs[1]  = '{ALU_SUB,  64'd9, 64'd9, 64'd0, 1'b1, 1};
        vecs[2]  = '{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1};
        vecs[3]  = '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1};
        vecs[4]  = '{ALU_SRA,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 5};
        vecs[5]  = '{ALU_SLL,  64'h1234, 64'd0, 64'h1234, 1'b0, 1};
        vecs[6]  = '{ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1};
        vecs[7]  = '{ALU_SRAW, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_C000_0000, 1'b0, 2};
        vecs[8]  = '{ALU_SRLW, 64'h8000_0000, 64'd1, 64'h4000_0000, 1'b0, 2};
        vecs[9]  = '{ALU_AND,  64'hF0, 64'h3C, 64'h30, 1'b0, 1};
        vecs[10] = '{ALU_OR,   64'hF0, 64'h0F, 64'hFF, 1'b0, 1};
        vecs[11] = '{ALU_XOR,  64'hFF, 64'h0F, 64'hF0, 1'b0, 1};
        vecs[12] = '{ALU_ILLEGAL, 64'h55, 64'hAA, 64'd0, 1'b1, 1};
        vecs[13] = '{ALU_SUBW, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
        vecs[14] = '{ALU_SLLW, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1'b0, 32};
        vecs[15] = '{ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 64};
        vecs[16] = '{ALU_SLL,  64'd1, 64'h41, 64'd2, 1'b0, 2};
        vecs[17] = '{ALU_SLLW, 64'd1, 64'h25, 64'h20, 1'b0, 6};
        vecs[18] = '{ALU_SRAW, 64'hFFFF_FFFF_8000_0001, 64'h20, 64'hFFFF_FFFF_8000_0001, 1'b0, 1};

        // Reset state
        #2;
        chk64("rst_result", bus.result, 64'd0);
        chk64("rst_zero", {63'd0, bus.zero}, 64'd0);
        chk64("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk64("rst_done", {63'd0, bus.done}, 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
            chk64($sformatf("v%0d_result", i), r, vecs[i].res);
            chk64($sformatf("v%0d_zero", i), {63'd0, z}, {63'd0, vecs[i].z});
            chkint($sformatf("v%0d_latency", i), lat, FAST ? 1 : vecs[i].lat);
            @(posedge clk);
            #1;
            chk64($sformatf("v%0d_busy_after", i), {63'd0, bus.busy, bus.done}, 64'd0);
        end

        // start pulsed during EXEC and during DONE must be ignored
        bus.start     = 1'b1;
        bus.operation = ALU_SRA;
        bus.A         = 64'h8000_0000_0000_0000;
        bus.B         = 64'd4;
        @(posedge clk);
        #1;
        chk64("ign_busy_rise", {63'd0, bus.busy}, 64'd1);
        bus.operation = ALU_ADD;
        bus.A         = 64'd1;
        bus.B         = 64'd1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                bus.start     = 1'b1;
                bus.operation = ALU_OR;
                bus.A         = 64'h1;
                bus.B         = 64'h2;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chkint("ign_done_count", dones, 1);
        chk64("ign_result", bus.result, 64'hF800_0000_0000_0000);
        chk64("ign_idle", {63'd0, bus.busy}, 64'd0);

        // Reset mid-way through sll by 63
        bus.start     = 1'b1;
        bus.operation = ALU_SLL;
        bus.A         = 64'd1;
        bus.B         = 64'd63;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk64("midrst_result", bus.result, 64'd0);
        chk64("midrst_flags", {61'd0, bus.zero, bus.busy, bus.done}, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(ALU_AND, 64'hF0, 64'h3C, r, z, lat);
        chk64("postrst_result", r, 64'h30);
        chk64("postrst_zero", {63'd0, z}, 64'd0);
        chkint("postrst_latency", lat, 1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
